// File: rtl/onehot_capture_fifo.sv
// Captures one-hot decoder lines, encodes them to a 3-bit index and queues them in a small FIFO.
// Rejected (non-one-hot) and dropped (overflow) samples are tracked by sticky flags and a saturating counter.
module onehot_capture_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ERR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_onehot,
    input  logic                     err_clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_code,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic [ERR_W-1:0]         err_count,
    output logic                     err_flag,
    output logic                     ovf_flag
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic [3:0]    ones;
    logic [2:0]    code;
    logic          is_onehot;
    logic          push;
    logic          pop;
    logic          bad;
    logic          drop;

    always_comb begin
        ones = '0;
        code = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            ones = ones + 4'(in_onehot[i]);
            if (in_onehot[i]) code = 3'(i);
        end
        is_onehot = (ones == 4'd1);
    end

    assign out_valid = (level != '0);
    assign full      = (level == LW'(DEPTH));
    // Head is masked so an empty FIFO always presents code 0.
    assign out_code  = out_valid ? mem[rd_ptr] : '0;

    assign pop  = out_valid && out_ready;
    assign push = in_valid && is_onehot && (!full || pop);
    assign drop = in_valid && is_onehot && full && !pop;
    assign bad  = in_valid && !is_onehot;

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
            err_flag  <= 1'b0;
            ovf_flag  <= 1'b0;
        end else if (err_clr) begin
            // An event coinciding with the clear is kept rather than lost.
            err_count <= bad ? ERR_W'(1) : '0;
            err_flag  <= bad;
            ovf_flag  <= drop;
        end else begin
            if (bad && (err_count != '1)) err_count <= err_count + ERR_W'(1);
            if (bad)  err_flag <= 1'b1;
            if (drop) ovf_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_onehot_capture_fifo.sv
// Directed bench for onehot_capture_fifo: a default instance plus a 2-bit error counter instance
// sharing the same stimulus.
module tb_onehot_capture_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_onehot;
    logic       err_clr;
    logic       out_ready;

    logic       out_valid,  s_out_valid;
    logic [2:0] out_code,   s_out_code;
    logic [2:0] level,      s_level;
    logic       full,       s_full;
    logic [7:0] err_count;
    logic [1:0] s_err_count;
    logic       err_flag,   s_err_flag;
    logic       ovf_flag,   s_ovf_flag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onehot_capture_fifo #(.DEPTH(4), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_onehot(in_onehot),
        .err_clr(err_clr), .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .level(level), .full(full),
        .err_count(err_count), .err_flag(err_flag), .ovf_flag(ovf_flag)
    );

    onehot_capture_fifo #(.DEPTH(4), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_onehot(in_onehot),
        .err_clr(err_clr), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_code(s_out_code), .level(s_level), .full(s_full),
        .err_count(s_err_count), .err_flag(s_err_flag), .ovf_flag(s_ovf_flag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] vec;
        rst = 1'b1; in_valid = 1'b0; in_onehot = 8'h00; err_clr = 1'b0; out_ready = 1'b0;
        step();
        chk("rst_level", 32'(level), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_code", 32'(out_code), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_errcnt", 32'(err_count), 0);
        chk("rst_errflag", 32'(err_flag), 0);
        chk("rst_ovf", 32'(ovf_flag), 0);
        rst = 1'b0;

        // Sweep every line with the consumer always ready
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vec = 8'h01 << i;
            in_onehot = vec;
            step();
            chk("sweep_valid", 32'(out_valid), 1);
            chk("sweep_code", 32'(out_code), 32'(i));
            chk("sweep_level", 32'(level), 1);
        end
        in_valid = 1'b0;
        step();
        chk("sweep_empty_level", 32'(level), 0);
        chk("sweep_empty_valid", 32'(out_valid), 0);
        chk("sweep_empty_code", 32'(out_code), 0);
        chk("sweep_errcnt", 32'(err_count), 0);

        // Fill with consumer stalled; head must hold
        out_ready = 1'b0; in_valid = 1'b1;
        in_onehot = 8'h04; step(); chk("fill1_level", 32'(level), 1); chk("fill1_code", 32'(out_code), 2);
        in_onehot = 8'h10; step(); chk("fill2_level", 32'(level), 2); chk("fill2_code", 32'(out_code), 2);
        in_onehot = 8'h80; step(); chk("fill3_level", 32'(level), 3); chk("fill3_full", 32'(full), 0);
        in_onehot = 8'h02; step(); chk("fill4_level", 32'(level), 4); chk("fill4_full", 32'(full), 1);
        chk("fill4_ovf", 32'(ovf_flag), 0);
        in_onehot = 8'h01; step();
        chk("ovf_flag", 32'(ovf_flag), 1);
        chk("ovf_level", 32'(level), 4);
        chk("ovf_code", 32'(out_code), 2);

        // Push and pop together while full
        in_onehot = 8'h20; out_ready = 1'b1;
        step();
        chk("pp_full_level", 32'(level), 4);
        chk("pp_full_full", 32'(full), 1);
        chk("drain_code0", 32'(out_code), 4);
        in_valid = 1'b0;
        step(); chk("drain_code1", 32'(out_code), 7); chk("drain_level1", 32'(level), 3);
        step(); chk("drain_code2", 32'(out_code), 1); chk("drain_level2", 32'(level), 2);
        step(); chk("drain_code3", 32'(out_code), 5); chk("drain_level3", 32'(level), 1);
        step(); chk("drain_empty_valid", 32'(out_valid), 0); chk("drain_empty_level", 32'(level), 0);

        // Pop on empty and invalid garbage input are ignored
        in_onehot = 8'h03;
        step();
        chk("underflow_level", 32'(level), 0);
        chk("ignored_errcnt", 32'(err_count), 0);
        chk("ignored_errflag", 32'(err_flag), 0);

        err_clr = 1'b1;
        step();
        chk("clr_ovf", 32'(ovf_flag), 0);
        chk("clr_errcnt", 32'(err_count), 0);
        err_clr = 1'b0;

        // Non-one-hot samples
        out_ready = 1'b0; in_valid = 1'b1;
        in_onehot = 8'h00; step(); chk("err1_cnt", 32'(err_count), 1); chk("err1_flag", 32'(err_flag), 1);
        in_onehot = 8'h03; step(); chk("err2_cnt", 32'(err_count), 2);
        in_onehot = 8'hFF; step(); chk("err3_cnt", 32'(err_count), 3); chk("err3_level", 32'(level), 0);
        chk("sat3_cnt", 32'(s_err_count), 3);
        in_onehot = 8'h81; step(); chk("err4_cnt", 32'(err_count), 4); chk("sat4_cnt", 32'(s_err_count), 3);
        in_onehot = 8'h00; step(); chk("err5_cnt", 32'(err_count), 5); chk("sat5_cnt", 32'(s_err_count), 3);
        chk("err5_valid", 32'(out_valid), 0);

        // Clear coinciding with an error
        err_clr = 1'b1; in_onehot = 8'h06;
        step();
        chk("clr_err_cnt", 32'(err_count), 1);
        chk("clr_err_flag", 32'(err_flag), 1);
        chk("clr_err_sat", 32'(s_err_count), 1);
        err_clr = 1'b0;

        // Reset with three entries queued
        in_onehot = 8'h08; step();
        in_onehot = 8'h40; step();
        in_onehot = 8'h01; step();
        chk("pre_rst_level", 32'(level), 3);
        chk("pre_rst_code", 32'(out_code), 3);
        rst = 1'b1; in_onehot = 8'h02; out_ready = 1'b1; err_clr = 1'b0;
        step();
        chk("midrst_level", 32'(level), 0);
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_code", 32'(out_code), 0);
        chk("midrst_errcnt", 32'(err_count), 0);
        chk("midrst_errflag", 32'(err_flag), 0);
        rst = 1'b0; in_valid = 1'b0;
        step();
        chk("postrst_level", 32'(level), 0);
        in_valid = 1'b1; in_onehot = 8'h10; out_ready = 1'b0;
        step();
        chk("postrst_code", 32'(out_code), 4);
        chk("postrst_level1", 32'(level), 1);

        // Fill, then overflow while clearing: overflow wins
        in_onehot = 8'h01; step(); step(); step();
        chk("refill_full", 32'(full), 1);
        err_clr = 1'b1; in_onehot = 8'h80;
        step();
        chk("clr_ovf_flag", 32'(ovf_flag), 1);
        chk("clr_ovf_level", 32'(level), 4);
        chk("clr_ovf_code", 32'(out_code), 4);
        err_clr = 1'b0; in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
